// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit with architectural HI/LO registers, placed
//   beside the ALU in EX. Shift-add multiply and restoring divide retire one
//   bit per cycle on operand magnitudes; a final FIXUP cycle applies signs
//   and writes HI/LO.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        launch an op (sampled only in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a    rs value (multiplicand / dividend)
//   operand_b    rt value (multiplier / divisor)
//   hi_we/lo_we  MTHI / MTLO write strobes (honoured only in IDLE)
//   wdata        MTHI / MTLO data
//   busy         operation in progress (stall request)
//   done         one-cycle pulse, HI/LO just updated
//   div_by_zero  qualifies done: the divisor was zero
//   hi, lo       architectural HI / LO registers
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]         op_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic               dbz_reg;
  logic [CW-1:0]      counter;
  // MUL: multiplicand magnitude. DIV: divisor magnitude.
  logic [WIDTH-1:0]   opnd_reg;
  // MUL: {product high, multiplier/product low}. DIV: {remainder, quotient}.
  // On divide-by-zero the upper half carries raw operand_a straight to HI.
  logic [2*WIDTH-1:0] acc;

  // Launch-time magnitudes; signed ops (op[0]=0) take two's-complement abs.
  logic             launch_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             launch_dbz;

  always_comb begin
    launch_signed = ~op[0];
    mag_a         = (launch_signed && operand_a[WIDTH-1]) ? (~operand_a + 1'b1) : operand_a;
    mag_b         = (launch_signed && operand_b[WIDTH-1]) ? (~operand_b + 1'b1) : operand_b;
    launch_dbz    = op[1] && (operand_b == '0);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = launch_dbz ? FIXUP : ITER;
        end
      end
      ITER: begin
        if (counter == CW'(WIDTH - 1)) begin
          state_next = FIXUP;
        end
      end
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One-bit-per-cycle datapath steps
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] div_step;

  always_comb begin
    // Multiply: conditional add into the upper half, carry kept so the
    // following right shift brings it into the MSB.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
    mul_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Divide: shifted remainder needs WIDTH+1 bits because the divisor may
    // use all WIDTH bits; the extra MSB of trial is the borrow.
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, opnd_reg};
    if (trial[WIDTH+1]) begin
      div_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and final HI/LO selection
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    quot     = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    prod_neg = ~acc + 1'b1;
    res_hi   = acc[2*WIDTH-1:WIDTH];
    res_lo   = acc[WIDTH-1:0];
    if (dbz_reg) begin
      res_hi = acc[2*WIDTH-1:WIDTH];
      res_lo = '1;
    end else if (op_reg[1]) begin
      // Sign flags are only ever set for signed ops, so DIVU passes through.
      res_lo = (sign_a_reg ^ sign_b_reg) ? (~quot + 1'b1) : quot;
      res_hi = sign_a_reg ? (~rem + 1'b1) : rem;
    end else if (sign_a_reg ^ sign_b_reg) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and architectural registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg      <= '0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      dbz_reg     <= 1'b0;
      counter     <= '0;
      opnd_reg    <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy        <= (state_next != IDLE);
      done        <= (state == FIXUP);
      div_by_zero <= (state == FIXUP) && dbz_reg;

      case (state)
        IDLE: begin
          // MTHI/MTLO land even when start is also high; the op result
          // overwrites them later.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_reg     <= op;
            sign_a_reg <= launch_signed && operand_a[WIDTH-1];
            sign_b_reg <= launch_signed && operand_b[WIDTH-1];
            dbz_reg    <= launch_dbz;
            counter    <= '0;
            if (launch_dbz) begin
              opnd_reg <= '0;
              acc      <= {operand_a, {WIDTH{1'b1}}};
            end else if (op[1]) begin
              opnd_reg <= mag_b;
              acc      <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd_reg <= mag_a;
              acc      <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        ITER: begin
          acc     <= op_reg[1] ? div_step : mul_step;
          counter <= counter + CW'(1);
        end
        FIXUP: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Table of hand-computed vectors applied through a scoreboard queue, plus
//   hand-written sequences for ignored start/MTHI, MTHI/MTLO in IDLE and
//   reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dbz;
    int           exp_lat;
  } vec_t;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[12];
  vec_t sb_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one op and follow it to done. If poke_at > 0, drive start (DIVU 9/3)
  // and hi_we (0xDEAD) for one cycle at that latency; both must be ignored.
  task automatic run_op(input vec_t v, input int poke_at);
    vec_t e;
    int   lat;
    bit   busy_ok;
    @(negedge clk);
    op = v.op; operand_a = v.a; operand_b = v.b; start = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == poke_at) begin
        start = 1'b1; op = DIVU; operand_a = 32'd9; operand_b = 32'd3;
        hi_we = 1'b1; wdata = 32'h0000DEAD;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0; hi_we = 1'b0;
    e = sb_q.pop_front();
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: op=%0d a=0x%08h b=0x%08h no done within 100 cycles", e.op, e.a, e.b);
    end else begin
      check("latency", W'(lat), W'(e.exp_lat));
      check("busy_before_done", {31'd0, busy_ok}, 32'd1);
      check("busy_in_done", {31'd0, busy}, 32'd0);
      check("hi", hi, e.exp_hi);
      check("lo", lo, e.exp_lo);
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.exp_dbz});
      $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0b lat=%0d",
               e.op, e.a, e.b, hi, lo, div_by_zero, lat);
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[4]  = '{DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 2};
    vecs[5]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    vecs[6]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
    vecs[7]  = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 34};
    vecs[8]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    vecs[9]  = '{DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 2};
    vecs[10] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 34};

    reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(vecs[i], 0);

    // start + MTHI mid-operation are ignored.
    begin
      vec_t v;
      v = '{MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 34};
      run_op(v, 5);
    end

    // MTLO in IDLE.
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h0000BEEF;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000BEEF);
    check("mtlo_hi_kept", hi, 32'd0);
    $display("MTLO 0xBEEF -> hi=0x%08h lo=0x%08h", hi, lo);

    // MTHI and MTLO together.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo_hi", hi, 32'hCAFEF00D);
    check("mthilo_lo", lo, 32'hCAFEF00D);
    $display("MTHI+MTLO 0xCAFEF00D -> hi=0x%08h lo=0x%08h", hi, lo);

    // Reset in the middle of a MULT.
    op = MULT; operand_a = 32'd1234; operand_b = 32'd5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_hi", hi, 32'd0);
    check("async_reset_lo", lo, 32'd0);
    $display("reset mid-op -> busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
    @(negedge clk);
    reset = 1'b0;
    begin
      vec_t v;
      v = '{MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34};
      run_op(v, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the EX stage. It consumes RegReadData1/RegReadData2 from ID/EX and the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO ops.
- Produces HI/LO for MFHI/MFLO, plus a busy flag that hazard logic uses to stall IF/ID and ID/EX.
- Shift-add multiply and restoring divide, one bit per cycle, on magnitudes with a final sign-fixup cycle.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch op; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  WIDTH  rs value (multiplicand / dividend)
- operand_b  input  WIDTH  rt value (multiplier / divisor)
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress; stall request
- done  output  1  one-cycle pulse, HI/LO just updated
- div_by_zero  output  1  qualifies done; divisor was 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- One clock; reset is asynchronous and active-high. While reset is high: state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter and datapath regs cleared.
- FSM states: IDLE, ITER, FIXUP.
- IDLE --start--> ITER, or IDLE --start with op[1]=1 and operand_b=0--> FIXUP.
- ITER stays for WIDTH cycles, then goes to FIXUP. FIXUP always returns to IDLE.
- Launch at edge of cycle T (start=1 in IDLE):
  - Latch op, the sign flags, |a| and |b|. Signed ops take the two's-complement magnitude; unsigned ops use operands raw.
  - Counter = 0.
- ITER (cycles T+1..T+WIDTH), one bit per cycle:
  - MUL: 2*WIDTH product accumulator. If the multiplier LSB is 1, add the multiplicand to the upper half with carry. Then shift right 1.
  - DIV: shift the {rem, quot} pair left 1. Trial-subtract the divisor from rem. If non-negative, keep the difference and set the quot LSB.
- FIXUP (cycle T+WIDTH+1):
  - Signed MULT: negate the 64-bit product if sign_a^sign_b.
  - Signed DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - At the end of FIXUP: {hi,lo} = product for MUL; lo = quotient and hi = remainder for DIV.
- Flags:
  - done=1 for exactly cycle T+WIDTH+2 (T+34 for WIDTH=32); hi/lo are valid from that cycle.
  - busy=1 for cycles T+1..T+WIDTH+1, and 0 in the done cycle.
- Divide by zero:
  - Iterations are skipped: FIXUP at T+1, done at T+2.
  - lo = all ones, hi = operand_a (raw).
  - div_by_zero=1 with done.
  - busy=1 only for cycle T+1.
- DIV 0x80000000 / 0xFFFFFFFF: the magnitude path gives lo=0x80000000, hi=0. No trap, no flag.
- MULTU/DIVU: no sign handling. MULT/DIV: operand bit WIDTH-1 is the sign.
- start while busy: ignored; no queuing, and the current op is unaffected.
- hi_we/lo_we:
  - Honoured only in IDLE; they write wdata at the edge.
  - Ignored while busy or in FIXUP.
  - In IDLE with start=1 in the same cycle, the write is applied and is later overwritten by the op result.
- hi_we and lo_we together in IDLE: both registers take wdata.
- Reset mid-operation aborts immediately. The unit returns to the reset values and accepts start on the first cycle after reset deasserts.
- Outputs are registered; no combinational input-to-output paths.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7, start at T -> busy T+1..T+33; done at T+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at T+34.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=0x12345678, b=0 -> done at T+2, div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678.
- MULTU 5*6 started; at T+5 pulse start (DIVU 9/3) and hi_we (wdata=0xDEAD) -> both ignored; result hi=0, lo=30. Then MTLO 0xBEEF in IDLE -> lo=0xBEEF next cycle. Then reset asserted at T'+10 of a new MULT -> hi=lo=0 and busy=0 immediately; a subsequent MULTU 2*3 yields lo=6.
